// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Supervises NUM_PLL PLL channels from a free-running clock that does not come
// from any of them. After reset every PLL is held in reset for a shared
// power-up window. Each channel then runs its own sequence:
//   reset pulse -> lock window -> stability filter -> locked.
// A window that expires is retried. Once the retry budget is used up, the
// channel latches into fault and keeps its PLL in reset. An external request
// or a global reset is the only way out of fault.
//
// Ports
//   independent_clk  in   1        sole clock, independent of the PLLs
//   rst              in   1        asynchronous active-high reset
//   extern_pll_rst   in   NUM_PLL  per-channel reset request (async level)
//   pll_lock         in   NUM_PLL  raw PLL lock indicators (async)
//   pll_rst          out  NUM_PLL  per-channel PLL reset, registered
//   locked           out  NUM_PLL  qualified lock per channel, registered
//   fault            out  NUM_PLL  retry budget exhausted, registered
//   all_locked       out  1        AND of locked
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int NUM_PLL         = 2,
    parameter int POWERUP_PERIOD  = 12_000_000,
    parameter int RST_PULSE       = 16,
    parameter int MAX_LOCK_PERIOD = 360_000,
    parameter int LOCK_STABLE     = 1024,
    parameter int MAX_RETRY       = 3
) (
    input  logic               independent_clk,
    input  logic               rst,
    input  logic [NUM_PLL-1:0] extern_pll_rst,
    input  logic [NUM_PLL-1:0] pll_lock,
    output logic [NUM_PLL-1:0] pll_rst,
    output logic [NUM_PLL-1:0] locked,
    output logic [NUM_PLL-1:0] fault,
    output logic               all_locked
);

    // The attempt counter times both the reset pulse and the lock window.
    localparam int ATTEMPT_MAX = (MAX_LOCK_PERIOD > RST_PULSE) ? MAX_LOCK_PERIOD : RST_PULSE;
    localparam int AW = $clog2(ATTEMPT_MAX + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int PW = (POWERUP_PERIOD > 0) ? $clog2(POWERUP_PERIOD + 1) : 1;

    localparam logic [AW-1:0] PULSE_LAST  = AW'(RST_PULSE - 1);
    localparam logic [AW-1:0] WINDOW_LAST = AW'(MAX_LOCK_PERIOD - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE - 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_ASSERT_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_LOCKED,
        ST_FAULT
    } state_t;

    localparam state_t RESET_STATE = (POWERUP_PERIOD == 0) ? ST_ASSERT_RST : ST_POWERUP;

    // -------------------------------------------------------------------------
    // Two-flop synchronisers for the asynchronous inputs.
    // -------------------------------------------------------------------------
    logic [NUM_PLL-1:0] lock_meta;
    logic [NUM_PLL-1:0] lock_s;
    logic [NUM_PLL-1:0] ext_meta;
    logic [NUM_PLL-1:0] ext_s;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its source, which is what makes the two stages a
    // real two-cycle pipeline instead of a single wire.
    always_ff @(posedge independent_clk or posedge rst) begin
        if (rst) begin
            lock_meta <= '0;
            lock_s    <= '0;
            ext_meta  <= '0;
            ext_s     <= '0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
            ext_meta  <= extern_pll_rst;
            ext_s     <= ext_meta;
        end
    end

    // -------------------------------------------------------------------------
    // Shared power-up window. The counter saturates on its last value. Channels
    // leave POWERUP together and only rst brings them back, so it never needs
    // to restart by itself.
    // -------------------------------------------------------------------------
    logic pwr_done;

    generate
        if (POWERUP_PERIOD > 0) begin : g_powerup
            localparam logic [PW-1:0] PWR_LAST = PW'(POWERUP_PERIOD - 1);
            logic [PW-1:0] pwr_cnt;

            always_ff @(posedge independent_clk or posedge rst) begin
                if (rst) begin
                    pwr_cnt <= '0;
                end else if (pwr_cnt != PWR_LAST) begin
                    pwr_cnt <= pwr_cnt + PW'(1);
                end
            end

            assign pwr_done = (pwr_cnt == PWR_LAST);
        end else begin : g_no_powerup
            assign pwr_done = 1'b1;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Per-channel sequencer. The channels share nothing except the power-up
    // window.
    // -------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_PLL; i++) begin : g_chan
            state_t        state;
            logic [AW-1:0] attempt_cnt;
            logic [SW-1:0] stable_cnt;
            logic [RW-1:0] retry_cnt;
            logic [RW-1:0] retry_next;
            logic          give_up;
            logic          ch_pll_rst;
            logic          ch_locked;
            logic          ch_fault;

            assign retry_next = retry_cnt + RW'(1);
            assign give_up    = (MAX_RETRY != 0) && (retry_next == RETRY_LIMIT);

            always_ff @(posedge independent_clk or posedge rst) begin
                if (rst) begin
                    state       <= RESET_STATE;
                    attempt_cnt <= '0;
                    stable_cnt  <= '0;
                    retry_cnt   <= '0;
                    ch_pll_rst  <= 1'b1;
                    ch_locked   <= 1'b0;
                    ch_fault    <= 1'b0;
                end else if (ext_s[i] && state != ST_POWERUP) begin
                    // An external request restarts the channel with a fresh budget.
                    // While it is held, the pulse counter keeps restarting.
                    state       <= ST_ASSERT_RST;
                    attempt_cnt <= '0;
                    retry_cnt   <= '0;
                    ch_pll_rst  <= 1'b1;
                    ch_locked   <= 1'b0;
                    ch_fault    <= 1'b0;
                end else begin
                    case (state)
                        ST_POWERUP: begin
                            if (pwr_done) begin
                                state       <= ST_WAIT_LOCK;
                                attempt_cnt <= '0;
                                ch_pll_rst  <= 1'b0;
                            end
                        end

                        ST_ASSERT_RST: begin
                            // ext_s is low here. A high ext_s took the branch above.
                            if (attempt_cnt == PULSE_LAST) begin
                                state       <= ST_WAIT_LOCK;
                                attempt_cnt <= '0;
                                ch_pll_rst  <= 1'b0;
                            end else begin
                                attempt_cnt <= attempt_cnt + AW'(1);
                            end
                        end

                        // One lock window spans both states. Dropping back from
                        // STABLE keeps the attempt count, so chatter cannot
                        // stretch the window.
                        ST_WAIT_LOCK, ST_STABLE: begin
                            if (state == ST_STABLE && lock_s[i] && stable_cnt == STABLE_LAST) begin
                                // Lock takes priority over a window expiring on the same edge.
                                state     <= ST_LOCKED;
                                retry_cnt <= '0;
                                ch_locked <= 1'b1;
                            end else if (attempt_cnt == WINDOW_LAST) begin
                                retry_cnt   <= retry_next;
                                attempt_cnt <= '0;
                                ch_pll_rst  <= 1'b1;
                                if (give_up) begin
                                    state    <= ST_FAULT;
                                    ch_fault <= 1'b1;
                                end else begin
                                    state <= ST_ASSERT_RST;
                                end
                            end else begin
                                attempt_cnt <= attempt_cnt + AW'(1);
                                if (state == ST_WAIT_LOCK) begin
                                    if (lock_s[i]) begin
                                        state      <= ST_STABLE;
                                        stable_cnt <= '0;
                                    end
                                end else if (lock_s[i]) begin
                                    stable_cnt <= stable_cnt + SW'(1);
                                end else begin
                                    state <= ST_WAIT_LOCK;
                                end
                            end
                        end

                        ST_LOCKED: begin
                            // Losing lock restarts the channel with a full budget.
                            if (!lock_s[i]) begin
                                state       <= ST_ASSERT_RST;
                                attempt_cnt <= '0;
                                retry_cnt   <= '0;
                                ch_locked   <= 1'b0;
                                ch_pll_rst  <= 1'b1;
                            end
                        end

                        ST_FAULT: begin
                            // Held with the PLL in reset until ext_s or rst.
                        end

                        default: begin
                            state       <= ST_ASSERT_RST;
                            attempt_cnt <= '0;
                            ch_pll_rst  <= 1'b1;
                            ch_locked   <= 1'b0;
                            ch_fault    <= 1'b0;
                        end
                    endcase
                end
            end

            assign pll_rst[i] = ch_pll_rst;
            assign locked[i]  = ch_locked;
            assign fault[i]   = ch_fault;
        end
    endgenerate

    assign all_locked = &locked;

endmodule
